// File: rtl/key_param_pkg.sv
// Shared constants for the front-panel parameter controller: key bits,
// parameter addresses, FSM encoding and a per-address table lookup.
package key_param_pkg;

    localparam int K_SEL_NEXT = 0;
    localparam int K_SEL_PREV = 1;
    localparam int K_INC      = 2;
    localparam int K_DEC      = 3;
    localparam int K_INC_BIG  = 4;
    localparam int K_DEC_BIG  = 5;
    localparam int K_APPLY    = 6;
    localparam int K_DEFAULTS = 7;

    localparam logic [1:0] P_TB   = 2'd0;
    localparam logic [1:0] P_GAIN = 2'd1;
    localparam logic [1:0] P_TRIG = 2'd2;
    localparam logic [1:0] P_FILT = 2'd3;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND} state_t;

    // Picks the MAX or DEF value belonging to a parameter address.
    function automatic int unsigned param_lut(input logic [1:0] addr,
                                              input int unsigned v_tb, v_gain,
                                              v_trig, v_filt);
        case (addr)
            P_TB:    param_lut = v_tb;
            P_GAIN:  param_lut = v_gain;
            P_TRIG:  param_lut = v_trig;
            default: param_lut = v_filt;
        endcase
    endfunction

endpackage

// File: rtl/key_param_ctrl_if.sv
// Datapath configuration port: one parameter word per valid/ready transfer.
interface key_param_ctrl_if #(parameter int PW = 8);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_addr;
    logic [PW-1:0] cfg_data;

    modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/key_param_ctrl_step.sv
// Saturating add/sub of a parameter value by a step, clamped to [0, max].
module param_sat_step #(
    parameter int PW = 8
) (
    input  logic [PW-1:0] value,
    input  logic [PW-1:0] step,
    input  logic          sub,
    input  logic [PW-1:0] max,
    output logic [PW-1:0] result
);
    logic [PW:0] wide;

    always_comb begin
        wide   = '0;
        result = value;
        if (sub) begin
            // A set top bit after the subtraction is a borrow, i.e. below zero.
            wide   = {1'b0, value} - {1'b0, step};
            result = wide[PW] ? '0 : wide[PW-1:0];
        end else begin
            wide   = {1'b0, value} + {1'b0, step};
            result = (wide > {1'b0, max}) ? max : wide[PW-1:0];
        end
    end
endmodule

// File: rtl/key_param_ctrl.sv
// Front-panel parameter controller: edits four shadow parameters from key
// pulses and pushes all of them to the datapath on APPLY, DEFAULTS or reset.
module key_param_ctrl
    import key_param_pkg::*;
#(
    parameter int          PW       = 8,
    parameter int unsigned TB_MAX   = 15,
    parameter int unsigned TB_DEF   = 4,
    parameter int unsigned GAIN_MAX = 7,
    parameter int unsigned GAIN_DEF = 0,
    parameter int unsigned TRIG_MAX = 255,
    parameter int unsigned TRIG_DEF = 128,
    parameter int unsigned FILT_MAX = 3,
    parameter int unsigned FILT_DEF = 0,
    parameter int unsigned STEP_BIG = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          key_pulse,
    key_param_ctrl_if.master    cfg,
    output logic [1:0]          sel,
    output logic [PW-1:0]       sel_value,
    output logic                dirty,
    output logic                busy
);
    localparam logic [3:0][PW-1:0] DEF_TAB =
        {PW'(FILT_DEF), PW'(TRIG_DEF), PW'(GAIN_DEF), PW'(TB_DEF)};

    state_t               state, state_nxt;
    logic [3:0][PW-1:0]   shadow, shadow_nxt;
    logic [1:0]           sel_nxt, addr, addr_nxt;
    logic                 dirty_nxt;
    logic                 step_sub, step_big;
    logic [PW-1:0]        step_amt, sel_max, step_res;

    assign sel_value     = shadow[sel];
    assign busy          = (state != ST_IDLE);
    assign cfg.cfg_valid = (state == ST_SEND);
    assign cfg.cfg_addr  = addr;
    assign cfg.cfg_data  = cfg.cfg_valid ? shadow[addr] : '0;

    // Step direction/size follows the highest-priority arithmetic key.
    always_comb begin
        step_sub = 1'b0;
        step_big = 1'b0;
        if (key_pulse[K_DEC_BIG]) begin
            step_sub = 1'b1;
            step_big = 1'b1;
        end else if (key_pulse[K_INC_BIG]) begin
            step_big = 1'b1;
        end else if (key_pulse[K_DEC]) begin
            step_sub = 1'b1;
        end
    end

    assign step_amt = step_big ? PW'(STEP_BIG) : PW'(1);
    assign sel_max  = PW'(param_lut(sel, TB_MAX, GAIN_MAX, TRIG_MAX, FILT_MAX));

    param_sat_step #(.PW(PW)) u_step (
        .value  (shadow[sel]),
        .step   (step_amt),
        .sub    (step_sub),
        .max    (sel_max),
        .result (step_res)
    );

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        sel_nxt    = sel;
        addr_nxt   = addr;
        dirty_nxt  = dirty;
        case (state)
            ST_INIT: begin
                state_nxt = ST_SEND;
                addr_nxt  = 2'd0;
            end
            ST_IDLE: begin
                if (key_pulse[K_DEFAULTS]) begin
                    shadow_nxt = DEF_TAB;
                    state_nxt  = ST_SEND;
                    addr_nxt   = 2'd0;
                end else if (key_pulse[K_APPLY]) begin
                    state_nxt = ST_SEND;
                    addr_nxt  = 2'd0;
                end else if (|key_pulse[K_DEC_BIG:K_INC]) begin
                    // Only a real change marks the shadow set dirty.
                    if (step_res != shadow[sel]) begin
                        shadow_nxt[sel] = step_res;
                        dirty_nxt       = 1'b1;
                    end
                end else if (key_pulse[K_SEL_PREV]) begin
                    sel_nxt = sel - 2'd1;
                end else if (key_pulse[K_SEL_NEXT]) begin
                    sel_nxt = sel + 2'd1;
                end
            end
            ST_SEND: begin
                if (cfg.cfg_ready) begin
                    if (addr == 2'd3) begin
                        state_nxt = ST_IDLE;
                        dirty_nxt = 1'b0;
                    end else begin
                        addr_nxt = addr + 2'd1;
                    end
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_INIT;
            shadow <= DEF_TAB;
            sel    <= 2'd0;
            addr   <= 2'd0;
            dirty  <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            sel    <= sel_nxt;
            addr   <= addr_nxt;
            dirty  <= dirty_nxt;
        end
    end
endmodule

// File: tb/tb_key_param_ctrl.sv
// Directed bench for key_param_ctrl: init push, editing, saturation,
// stalled apply, ignored keys during a push and reset abort.
module tb_key_param_ctrl;
    logic       clk;
    logic       rst_n;
    logic [7:0] key_pulse;
    logic [1:0] sel;
    logic [7:0] sel_value;
    logic       dirty, busy;
    int         n_vec, n_err;

    key_param_ctrl_if #(.PW(8)) cfg_bus ();

    key_param_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_pulse (key_pulse),
        .cfg       (cfg_bus),
        .sel       (sel),
        .sel_value (sel_value),
        .dirty     (dirty),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        key_pulse = k;
        tick();
        key_pulse = '0;
    endtask

    task automatic test_reset;
        logic [7:0] exp_data [4] = '{8'd4, 8'd0, 8'd128, 8'd0};
        rst_n = 1'b0; key_pulse = '0; cfg_bus.cfg_ready = 1'b1;
        repeat (3) tick();
        n_vec++; if (cfg_bus.cfg_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", cfg_bus.cfg_valid); end
        n_vec++; if (cfg_bus.cfg_addr !== 2'd0) begin n_err++; $display("FAIL rst_addr got %0d want 0", cfg_bus.cfg_addr); end
        n_vec++; if (cfg_bus.cfg_data !== 8'd0) begin n_err++; $display("FAIL rst_data got %0d want 0", cfg_bus.cfg_data); end
        n_vec++; if (busy !== 1'b1 || dirty !== 1'b0) begin n_err++; $display("FAIL rst_flags got busy=%0b dirty=%0b want 1/0", busy, dirty); end
        n_vec++; if (sel !== 2'd0 || sel_value !== 8'd4) begin n_err++; $display("FAIL rst_sel got %0d/%0d want 0/4", sel, sel_value); end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (cfg_bus.cfg_valid !== 1'b1 || cfg_bus.cfg_addr !== 2'(k) || cfg_bus.cfg_data !== exp_data[k]) begin
                n_err++;
                $display("FAIL init_push[%0d] got v=%0b a=%0d d=%0d want 1/%0d/%0d", k, cfg_bus.cfg_valid, cfg_bus.cfg_addr, cfg_bus.cfg_data, k, exp_data[k]);
            end
            tick();
        end
        n_vec++; if (cfg_bus.cfg_valid !== 1'b0 || busy !== 1'b0 || dirty !== 1'b0) begin n_err++; $display("FAIL init_done got v=%0b busy=%0b dirty=%0b want 0/0/0", cfg_bus.cfg_valid, busy, dirty); end
        n_vec++; if (sel !== 2'd0 || sel_value !== 8'd4) begin n_err++; $display("FAIL init_sel got %0d/%0d want 0/4", sel, sel_value); end
    endtask

    task automatic test_floor_and_wrap;
        press(8'h01);  // SEL_NEXT -> gain
        n_vec++; if (sel !== 2'd1 || sel_value !== 8'd0) begin n_err++; $display("FAIL sel_next got %0d/%0d want 1/0", sel, sel_value); end
        press(8'h08);  // DEC at 0
        n_vec++; if (sel_value !== 8'd0 || dirty !== 1'b0) begin n_err++; $display("FAIL dec_floor got %0d dirty=%0b want 0/0", sel_value, dirty); end
        press(8'h20);  // DEC_BIG at 0
        n_vec++; if (sel_value !== 8'd0 || dirty !== 1'b0) begin n_err++; $display("FAIL decbig_floor got %0d dirty=%0b want 0/0", sel_value, dirty); end
        press(8'h02);
        press(8'h02);  // 1 -> 0 -> 3
        n_vec++; if (sel !== 2'd3 || sel_value !== 8'd0) begin n_err++; $display("FAIL sel_prev_wrap got %0d/%0d want 3/0", sel, sel_value); end
    endtask

    task automatic test_trig_sat;
        int exp_v;
        press(8'h01);  // 3 -> 0 wrap
        n_vec++; if (sel !== 2'd0 || sel_value !== 8'd4) begin n_err++; $display("FAIL sel_next_wrap got %0d/%0d want 0/4", sel, sel_value); end
        press(8'h01);
        press(8'h01);
        n_vec++; if (sel !== 2'd2 || sel_value !== 8'd128) begin n_err++; $display("FAIL sel_trig got %0d/%0d want 2/128", sel, sel_value); end
        exp_v = 128;
        for (int i = 0; i < 10; i++) begin
            press(8'h10);
            exp_v = (exp_v + 16 > 255) ? 255 : exp_v + 16;
            n_vec++;
            if (sel_value !== 8'(exp_v) || dirty !== 1'b1) begin
                n_err++;
                $display("FAIL incbig[%0d] got %0d dirty=%0b want %0d/1", i, sel_value, dirty, exp_v);
            end
        end
        press(8'h04);  // INC at max
        n_vec++; if (sel_value !== 8'd255) begin n_err++; $display("FAIL inc_at_max got %0d want 255", sel_value); end
    endtask

    task automatic test_apply_stall;
        logic [7:0] exp_data [4] = '{8'd4, 8'd0, 8'd255, 8'd0};
        logic       rdy [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int xfers, c;
        press(8'h40);
        xfers = 0; c = 0;
        while (xfers < 4 && c < 12) begin
            cfg_bus.cfg_ready = rdy[c];
            key_pulse = (c == 1) ? 8'h08 : 8'h00;  // DEC mid-push must be ignored
            n_vec++;
            if (cfg_bus.cfg_valid !== 1'b1 || busy !== 1'b1 || cfg_bus.cfg_addr !== 2'(xfers) || cfg_bus.cfg_data !== exp_data[xfers]) begin
                n_err++;
                $display("FAIL apply_cyc[%0d] got v=%0b b=%0b a=%0d d=%0d want 1/1/%0d/%0d", c, cfg_bus.cfg_valid, busy, cfg_bus.cfg_addr, cfg_bus.cfg_data, xfers, exp_data[xfers]);
            end
            if (rdy[c]) xfers++;
            tick();
            c++;
        end
        key_pulse = '0;
        cfg_bus.cfg_ready = 1'b1;
        n_vec++; if (xfers != 4) begin n_err++; $display("FAIL apply_timeout got %0d transfers want 4", xfers); end
        n_vec++; if (cfg_bus.cfg_valid !== 1'b0 || busy !== 1'b0 || dirty !== 1'b0) begin n_err++; $display("FAIL apply_done got v=%0b b=%0b d=%0b want 0/0/0", cfg_bus.cfg_valid, busy, dirty); end
        n_vec++; if (sel_value !== 8'd255) begin n_err++; $display("FAIL key_in_send got %0d want 255", sel_value); end
    endtask

    task automatic test_simultaneous;
        logic [7:0] exp_data [4] = '{8'd4, 8'd0, 8'd255, 8'd0};
        press(8'h02);  // -> gain
        press(8'h44);  // INC + APPLY
        n_vec++; if (sel !== 2'd1 || sel_value !== 8'd0) begin n_err++; $display("FAIL simul_shadow got %0d/%0d want 1/0", sel, sel_value); end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (cfg_bus.cfg_valid !== 1'b1 || cfg_bus.cfg_addr !== 2'(k) || cfg_bus.cfg_data !== exp_data[k]) begin
                n_err++;
                $display("FAIL simul_push[%0d] got v=%0b a=%0d d=%0d want 1/%0d/%0d", k, cfg_bus.cfg_valid, cfg_bus.cfg_addr, cfg_bus.cfg_data, k, exp_data[k]);
            end
            tick();
        end
        n_vec++; if (busy !== 1'b0 || dirty !== 1'b0) begin n_err++; $display("FAIL simul_done got b=%0b d=%0b want 0/0", busy, dirty); end
    endtask

    task automatic test_defaults_reset;
        logic [7:0] exp_data [4] = '{8'd4, 8'd0, 8'd128, 8'd0};
        press(8'h04);  // gain 0 -> 1
        n_vec++; if (sel_value !== 8'd1 || dirty !== 1'b1) begin n_err++; $display("FAIL gain_inc got %0d dirty=%0b want 1/1", sel_value, dirty); end
        press(8'h80);
        n_vec++; if (sel !== 2'd1 || sel_value !== 8'd0) begin n_err++; $display("FAIL defaults_shadow got %0d/%0d want 1/0", sel, sel_value); end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (cfg_bus.cfg_valid !== 1'b1 || cfg_bus.cfg_addr !== 2'(k) || cfg_bus.cfg_data !== exp_data[k]) begin
                n_err++;
                $display("FAIL defaults_push[%0d] got v=%0b a=%0d d=%0d want 1/%0d/%0d", k, cfg_bus.cfg_valid, cfg_bus.cfg_addr, cfg_bus.cfg_data, k, exp_data[k]);
            end
            if (k < 2) tick();
        end
        rst_n = 1'b0;  // abort while addr 2 is on the bus
        #1;
        n_vec++; if (cfg_bus.cfg_valid !== 1'b0 || cfg_bus.cfg_addr !== 2'd0 || busy !== 1'b1) begin n_err++; $display("FAIL abort got v=%0b a=%0d b=%0b want 0/0/1", cfg_bus.cfg_valid, cfg_bus.cfg_addr, busy); end
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (cfg_bus.cfg_valid !== 1'b1 || cfg_bus.cfg_addr !== 2'(k) || cfg_bus.cfg_data !== exp_data[k]) begin
                n_err++;
                $display("FAIL restart_push[%0d] got v=%0b a=%0d d=%0d want 1/%0d/%0d", k, cfg_bus.cfg_valid, cfg_bus.cfg_addr, cfg_bus.cfg_data, k, exp_data[k]);
            end
            tick();
        end
        n_vec++; if (busy !== 1'b0 || sel !== 2'd0 || sel_value !== 8'd4) begin n_err++; $display("FAIL restart_done got b=%0b sel=%0d val=%0d want 0/0/4", busy, sel, sel_value); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        key_pulse = '0;
        cfg_bus.cfg_ready = 1'b1;
        test_reset();
        test_floor_and_wrap();
        test_trig_sat();
        test_apply_stall();
        test_simultaneous();
        test_defaults_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
